// File: rtl/mem_access.sv
// mem_access: memory-access stage after execute; drives the req/addr_ok/data_ok data bus, flags
// address errors and aligns load data. Define MEM_BYTE_STROBE_EN to add the data_wstrb_o output.
package mem_access_pkg;
    localparam logic [7:0] ALUOP_LB  = 8'h80;
    localparam logic [7:0] ALUOP_LBU = 8'h81;
    localparam logic [7:0] ALUOP_LH  = 8'h82;
    localparam logic [7:0] ALUOP_LHU = 8'h83;
    localparam logic [7:0] ALUOP_LW  = 8'h84;
    localparam logic [7:0] ALUOP_SB  = 8'h88;
    localparam logic [7:0] ALUOP_SH  = 8'h89;
    localparam logic [7:0] ALUOP_SW  = 8'h8A;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned EXC_ADEL_BIT = 27,
    parameter int unsigned EXC_ADES_BIT = 26
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [31:0]       pc_i,
    input  logic [7:0]        aluop_i,
    input  logic [31:0]       alu_data_i,
    input  logic [31:0]       ram_write_data_i,
    input  logic              regfile_write_enable_i,
    input  logic [4:0]        regfile_write_addr_i,
    input  logic [31:0]       exception_type_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o,
`ifdef MEM_BYTE_STROBE_EN
    output logic [3:0]        data_wstrb_o,
`endif
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [31:0]       data_rdata_i,
    output logic [31:0]       pc_o,
    output logic              regfile_write_enable_o,
    output logic [4:0]        regfile_write_addr_o,
    output logic [31:0]       regfile_write_data_o,
    output logic [31:0]       exception_type_o,
    output logic [31:0]       bad_vaddr_o,
    output logic              mem_stall_request_o
);

    localparam logic [31:0] ADEL_MASK = 32'd1 << EXC_ADEL_BIT;
    localparam logic [31:0] ADES_MASK = 32'd1 << EXC_ADES_BIT;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        is_load, is_store, is_mem, sign_ext, misaligned, go;
    logic [1:0]  op_size;
    logic [31:0] st_data;
    logic        req_active;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [1:0]  bus_size;
    logic        bus_wr;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        op_size  = 2'd2;
        case (aluop_i)
            ALUOP_LB:  begin is_load  = 1'b1; sign_ext = 1'b1; op_size = 2'd0; end
            ALUOP_LBU: begin is_load  = 1'b1; op_size = 2'd0; end
            ALUOP_LH:  begin is_load  = 1'b1; sign_ext = 1'b1; op_size = 2'd1; end
            ALUOP_LHU: begin is_load  = 1'b1; op_size = 2'd1; end
            ALUOP_LW:  begin is_load  = 1'b1; op_size = 2'd2; end
            ALUOP_SB:  begin is_store = 1'b1; op_size = 2'd0; end
            ALUOP_SH:  begin is_store = 1'b1; op_size = 2'd1; end
            ALUOP_SW:  begin is_store = 1'b1; op_size = 2'd2; end
            default:   ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = is_mem & (((op_size == 2'd1) & alu_data_i[0]) |
                                  ((op_size == 2'd2) & (alu_data_i[1:0] != 2'b00)));
    assign go         = is_mem & ~misaligned & (exception_type_i == '0) & ~flush_i;

    always_comb begin
        case (op_size)
            2'd0:    st_data = {4{ram_write_data_i[7:0]}};
            2'd1:    st_data = {2{ram_write_data_i[15:0]}};
            default: st_data = ram_write_data_i;
        endcase
    end

    // A flush that coincides with the response still consumes it, so the bus never owes us data.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    addr_d  = alu_data_i;
                    size_d  = op_size;
                    wr_d    = is_store;
                    wdata_d = st_data;
                    if (data_addr_ok_i && data_data_ok_i) begin
                        state_d = S_DONE;
                        rdata_d = data_rdata_i;
                    end else if (data_addr_ok_i) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (data_addr_ok_i && data_data_ok_i) begin
                    state_d = flush_i ? S_IDLE : S_DONE;
                    if (!flush_i) rdata_d = data_rdata_i;
                end else if (data_addr_ok_i) begin
                    state_d = flush_i ? S_DROP : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_data_ok_i) begin
                    state_d = flush_i ? S_IDLE : S_DONE;
                    if (!flush_i) rdata_d = data_rdata_i;
                end else if (flush_i) begin
                    state_d = S_DROP;
                end
            end
            S_DONE: begin
                if (flush_i || !stall_i) state_d = S_IDLE;
            end
            S_DROP: begin
                if (data_data_ok_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // While waiting for addr_ok the request is driven from the captured copy so it cannot drift.
    assign req_active = ((state_q == S_IDLE) & go) | (state_q == S_REQ);
    assign bus_addr   = (state_q == S_REQ) ? addr_q  : alu_data_i;
    assign bus_size   = (state_q == S_REQ) ? size_q  : op_size;
    assign bus_wr     = (state_q == S_REQ) ? wr_q    : is_store;
    assign bus_wdata  = (state_q == S_REQ) ? wdata_q : st_data;

    assign ld_b = rdata_q[{alu_data_i[1:0], 3'b000} +: 8];
    assign ld_h = rdata_q[{alu_data_i[1], 4'b0000} +: 16];

    always_comb begin
        case (op_size)
            2'd0:    load_data = sign_ext ? {{24{ld_b[7]}}, ld_b} : {24'h0, ld_b};
            2'd1:    load_data = sign_ext ? {{16{ld_h[15]}}, ld_h} : {16'h0, ld_h};
            default: load_data = rdata_q;
        endcase
    end

`ifdef MEM_BYTE_STROBE_EN
    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    byte_strobe = 4'b0001 << off;
            2'd1:    byte_strobe = 4'b0011 << {off[1], 1'b0};
            default: byte_strobe = 4'b1111;
        endcase
    endfunction
`endif

    // Outputs are held at zero while reset is asserted, independent of the upstream inputs.
    always_comb begin
        data_req_o             = 1'b0;
        data_wr_o              = 1'b0;
        data_size_o            = '0;
        data_addr_o            = '0;
        data_wdata_o           = '0;
`ifdef MEM_BYTE_STROBE_EN
        data_wstrb_o           = '0;
`endif
        pc_o                   = '0;
        regfile_write_enable_o = 1'b0;
        regfile_write_addr_o   = '0;
        regfile_write_data_o   = '0;
        exception_type_o       = '0;
        bad_vaddr_o            = '0;
        mem_stall_request_o    = 1'b0;
        if (reset_i) begin
            data_req_o = req_active;
            if (req_active) begin
                data_wr_o    = bus_wr;
                data_size_o  = bus_size;
                data_addr_o  = ADDR_W'(bus_addr);
                data_wdata_o = bus_wdata;
`ifdef MEM_BYTE_STROBE_EN
                data_wstrb_o = bus_wr ? byte_strobe(bus_size, bus_addr[1:0]) : 4'b0000;
`endif
            end
            pc_o                   = pc_i;
            regfile_write_enable_o = regfile_write_enable_i & ~flush_i &
                                     (is_load ? (state_q == S_DONE) : ~is_store);
            regfile_write_addr_o   = regfile_write_addr_i;
            regfile_write_data_o   = is_load ? load_data : alu_data_i;
            exception_type_o       = exception_type_i |
                                     ((misaligned & is_load)  ? ADEL_MASK : 32'h0) |
                                     ((misaligned & is_store) ? ADES_MASK : 32'h0);
            bad_vaddr_o            = misaligned ? alu_data_i : 32'h0;
            mem_stall_request_o    = req_active | (state_q == S_WAIT) | (state_q == S_DROP);
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors, directed multi-cycle sequences and random transactions for mem_access,
// checked against a transaction-level model of bus timing, alignment and load/store data.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] OP_ADDU = 8'h21;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [31:0] pc_i, alu_data_i, ram_write_data_i, exception_type_i, data_rdata_i;
    logic [7:0]  aluop_i;
    logic        regfile_write_enable_i, stall_i, flush_i, data_addr_ok_i, data_data_ok_i;
    logic [4:0]  regfile_write_addr_i;
    logic        data_req_o, data_wr_o, regfile_write_enable_o, mem_stall_request_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o, data_wdata_o, pc_o, regfile_write_data_o, exception_type_o, bad_vaddr_o;
    logic [4:0]  regfile_write_addr_o;
`ifdef MEM_BYTE_STROBE_EN
    logic [3:0]  data_wstrb_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock_i = ~clock_i;

    mem_access #(.ADDR_W(32), .EXC_ADEL_BIT(27), .EXC_ADES_BIT(26)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .pc_i(pc_i), .aluop_i(aluop_i),
        .alu_data_i(alu_data_i), .ram_write_data_i(ram_write_data_i),
        .regfile_write_enable_i(regfile_write_enable_i), .regfile_write_addr_i(regfile_write_addr_i),
        .exception_type_i(exception_type_i), .stall_i(stall_i), .flush_i(flush_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
`ifdef MEM_BYTE_STROBE_EN
        .data_wstrb_o(data_wstrb_o),
`endif
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
        .pc_o(pc_o), .regfile_write_enable_o(regfile_write_enable_o),
        .regfile_write_addr_o(regfile_write_addr_o), .regfile_write_data_o(regfile_write_data_o),
        .exception_type_o(exception_type_o), .bad_vaddr_o(bad_vaddr_o),
        .mem_stall_request_o(mem_stall_request_o)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, rt, rdata, exc;
        logic        we;
        int unsigned a_dly, d_dly;
        bit          go;
        logic [31:0] e_wdata;
        logic [1:0]  e_size;
        logic        e_wr;
        logic [31:0] e_rf;
        logic        e_we;
        logic [31:0] e_exc, e_badv;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access width in bytes (0 = not a memory op).
    function automatic int unsigned msize(input logic [7:0] op);
        case (op)
            ALUOP_LB, ALUOP_LBU, ALUOP_SB: return 1;
            ALUOP_LH, ALUOP_LHU, ALUOP_SH: return 2;
            ALUOP_LW, ALUOP_SW:            return 4;
            default:                       return 0;
        endcase
    endfunction

    function automatic bit m_is_load(input logic [7:0] op);
        return op == ALUOP_LB || op == ALUOP_LBU || op == ALUOP_LH || op == ALUOP_LHU || op == ALUOP_LW;
    endfunction

    function automatic bit m_is_store(input logic [7:0] op);
        return op == ALUOP_SB || op == ALUOP_SH || op == ALUOP_SW;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] rt);
        logic [31:0] w;
        int unsigned n;
        n = msize(op);
        w = rt;
        if (n != 0)
            for (int lane = 0; lane < 4; lane++)
                w[8*lane +: 8] = rt[8*(lane % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned n;
        logic [31:0] v, mask;
        n = msize(op);
        v = rdata >> (8 * (addr % 4));
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            v = v & mask;
            if ((op == ALUOP_LB || op == ALUOP_LH) && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_strobe(input logic [7:0] op, input logic [31:0] addr);
        int unsigned n;
        n = msize(op);
        if (!m_is_store(op)) return 4'b0000;
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic vec_t model_vec(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                       input logic [31:0] rdata, input logic [31:0] exc, input logic we,
                                       input int unsigned a, input int unsigned d);
        vec_t v;
        int unsigned n;
        bit mis;
        n = msize(op);
        mis = (n != 0) && ((addr % n) != 0);
        v.op = op; v.addr = addr; v.rt = rt; v.rdata = rdata; v.exc = exc; v.we = we;
        v.a_dly = a; v.d_dly = d;
        v.go      = (n != 0) && !mis && (exc == 32'h0);
        v.e_wdata = m_wdata(op, rt);
        v.e_size  = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
        v.e_wr    = m_is_store(op);
        v.e_rf    = m_is_load(op) ? m_load(op, addr, rdata) : addr;
        v.e_we    = we && ((n == 0) || (m_is_load(op) && v.go));
        v.e_exc   = exc | ((mis && m_is_load(op)) ? (32'd1 << 27) : 32'h0)
                        | ((mis && m_is_store(op)) ? (32'd1 << 26) : 32'h0);
        v.e_badv  = mis ? addr : 32'h0;
        return v;
    endfunction

    task automatic set_instr(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt,
                             input logic we);
        pc_i = $urandom; aluop_i = op; alu_data_i = addr; ram_write_data_i = rt;
        regfile_write_enable_i = we; regfile_write_addr_i = 5'($urandom);
        exception_type_i = 32'h0; flush_i = 1'b0; stall_i = 1'b0;
    endtask

    task automatic set_nop();
        set_instr(OP_ADDU, 32'h0, 32'h0, 1'b0);
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_req"}, data_req_o, 1'b0);
        chk1({tag, "_wr"}, data_wr_o, 1'b0);
        chk({tag, "_size"}, 32'(data_size_o), 32'h0);
        chk({tag, "_addr"}, data_addr_o, 32'h0);
        chk({tag, "_wdata"}, data_wdata_o, 32'h0);
        chk({tag, "_pc"}, pc_o, 32'h0);
        chk1({tag, "_we"}, regfile_write_enable_o, 1'b0);
        chk({tag, "_rd"}, 32'(regfile_write_addr_o), 32'h0);
        chk({tag, "_rf"}, regfile_write_data_o, 32'h0);
        chk({tag, "_exc"}, exception_type_o, 32'h0);
        chk({tag, "_badv"}, bad_vaddr_o, 32'h0);
        chk1({tag, "_stall"}, mem_stall_request_o, 1'b0);
`ifdef MEM_BYTE_STROBE_EN
        chk({tag, "_strb"}, 32'(data_wstrb_o), 32'h0);
`endif
    endtask

    // Entered and left at posedge+1 with the FSM idle.
    task automatic run_txn(input vec_t v);
        int unsigned last;
        set_instr(v.op, v.addr, v.rt, v.we);
        exception_type_i = v.exc;
        if (!v.go) begin
            data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = $urandom;
            #1;
            chk1("pass_req", data_req_o, 1'b0);
            chk1("pass_stall", mem_stall_request_o, 1'b0);
            chk1("pass_we", regfile_write_enable_o, v.e_we);
            if (msize(v.op) == 0) chk("pass_rf", regfile_write_data_o, v.e_rf);
            chk("pass_exc", exception_type_o, v.e_exc);
            chk("pass_badv", bad_vaddr_o, v.e_badv);
            chk("pass_pc", pc_o, pc_i);
            chk("pass_rd", 32'(regfile_write_addr_o), 32'(regfile_write_addr_i));
            @(posedge clock_i); #1;
            return;
        end
        last = v.a_dly + v.d_dly;
        for (int unsigned k = 0; k <= last; k++) begin
            data_addr_ok_i = (k == v.a_dly);
            data_data_ok_i = (k == last);
            data_rdata_i   = (k == last) ? v.rdata : $urandom;
            #1;
            chk1("busy_req", data_req_o, k <= v.a_dly);
            chk1("busy_stall", mem_stall_request_o, 1'b1);
            chk1("busy_we", regfile_write_enable_o, 1'b0);
            if (k <= v.a_dly) begin
                chk("bus_addr", data_addr_o, v.addr);
                chk("bus_size", 32'(data_size_o), 32'(v.e_size));
                chk1("bus_wr", data_wr_o, v.e_wr);
                if (v.e_wr) chk("bus_wdata", data_wdata_o, v.e_wdata);
`ifdef MEM_BYTE_STROBE_EN
                chk("bus_strb", 32'(data_wstrb_o), 32'(m_strobe(v.op, v.addr)));
`endif
            end
            @(posedge clock_i); #1;
        end
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = $urandom;
        #1;
        chk1("done_req", data_req_o, 1'b0);
        chk1("done_stall", mem_stall_request_o, 1'b0);
        chk1("done_we", regfile_write_enable_o, v.e_we);
        if (m_is_load(v.op)) chk("done_rf", regfile_write_data_o, v.e_rf);
        chk("done_exc", exception_type_o, v.e_exc);
        chk("done_pc", pc_o, pc_i);
        @(posedge clock_i); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        vec_t v;
        logic [7:0] ops[9];

        // op, addr, rt, rdata, exc, we, a, d, go, e_wdata, e_size, e_wr, e_rf, e_we, e_exc, e_badv
        tbl[0]  = '{ALUOP_LW,  32'h1000, 32'h0,        32'hDEADBEEF, 32'h0,  1'b1, 2, 1, 1'b1, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        32'h0};
        tbl[1]  = '{ALUOP_LB,  32'h1003, 32'h11223344, 32'h80FFFFFF, 32'h0,  1'b1, 0, 0, 1'b1, 32'h44444444, 2'd0, 1'b0, 32'hFFFFFF80, 1'b1, 32'h0,        32'h0};
        tbl[2]  = '{ALUOP_LBU, 32'h1003, 32'h11223344, 32'h80FFFFFF, 32'h0,  1'b1, 1, 0, 1'b1, 32'h44444444, 2'd0, 1'b0, 32'h00000080, 1'b1, 32'h0,        32'h0};
        tbl[3]  = '{ALUOP_LH,  32'h1002, 32'h11223344, 32'h80011234, 32'h0,  1'b1, 0, 2, 1'b1, 32'h33443344, 2'd1, 1'b0, 32'hFFFF8001, 1'b1, 32'h0,        32'h0};
        tbl[4]  = '{ALUOP_LHU, 32'h1000, 32'h0,        32'h80019234, 32'h0,  1'b1, 1, 1, 1'b1, 32'h0,        2'd1, 1'b0, 32'h00009234, 1'b1, 32'h0,        32'h0};
        tbl[5]  = '{ALUOP_SH,  32'h2002, 32'h1234ABCD, 32'h0,        32'h0,  1'b1, 1, 0, 1'b1, 32'hABCDABCD, 2'd1, 1'b1, 32'h00002002, 1'b0, 32'h0,        32'h0};
        tbl[6]  = '{ALUOP_SB,  32'h3001, 32'h000000A5, 32'h0,        32'h0,  1'b1, 0, 1, 1'b1, 32'hA5A5A5A5, 2'd0, 1'b1, 32'h00003001, 1'b0, 32'h0,        32'h0};
        tbl[7]  = '{ALUOP_SW,  32'h1002, 32'h55555555, 32'h0,        32'h0,  1'b1, 0, 0, 1'b0, 32'h0,        2'd2, 1'b1, 32'h0,        1'b0, 32'h04000000, 32'h1002};
        tbl[8]  = '{ALUOP_LH,  32'h1001, 32'h0,        32'h0,        32'h0,  1'b1, 0, 0, 1'b0, 32'h0,        2'd1, 1'b0, 32'h0,        1'b0, 32'h08000000, 32'h1001};
        tbl[9]  = '{OP_ADDU,   32'h12345678, 32'h0,    32'h0,        32'h0,  1'b1, 0, 0, 1'b0, 32'h0,        2'd0, 1'b0, 32'h12345678, 1'b1, 32'h0,        32'h0};
        tbl[10] = '{ALUOP_LW,  32'h1004, 32'h0,        32'h0,        32'h10, 1'b1, 0, 0, 1'b0, 32'h0,        2'd2, 1'b0, 32'h0,        1'b0, 32'h10,         32'h0};
        tbl[11] = '{ALUOP_SW,  32'h4000, 32'hCAFEF00D, 32'h0,        32'h0,  1'b0, 3, 0, 1'b1, 32'hCAFEF00D, 2'd2, 1'b1, 32'h00004000, 1'b0, 32'h0,        32'h0};
        tbl[12] = '{ALUOP_LB,  32'h1001, 32'h0,        32'h12345678, 32'h0,  1'b1, 0, 0, 1'b1, 32'h0,        2'd0, 1'b0, 32'h00000056, 1'b1, 32'h0,        32'h0};
        tbl[13] = '{ALUOP_LHU, 32'h1002, 32'h0,        32'h80019234, 32'h0,  1'b1, 0, 0, 1'b1, 32'h0,        2'd1, 1'b0, 32'h00008001, 1'b1, 32'h0,        32'h0};
        tbl[14] = '{ALUOP_LW,  32'h1003, 32'h0,        32'h0,        32'h0,  1'b1, 0, 0, 1'b0, 32'h0,        2'd2, 1'b0, 32'h0,        1'b0, 32'h08000000, 32'h1003};

        ops = '{ALUOP_LB, ALUOP_LBU, ALUOP_LH, ALUOP_LHU, ALUOP_LW, ALUOP_SB, ALUOP_SH, ALUOP_SW, OP_ADDU};

        // Reset with a ready-to-issue load and an eager bus on the inputs: everything must read 0.
        reset_i = 1'b0;
        set_instr(ALUOP_LW, 32'h1000, 32'h0, 1'b1);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
        repeat (2) @(posedge clock_i);
        #1;
        check_all_zero("reset");
        set_nop();
        reset_i = 1'b1;
        @(posedge clock_i); #1;

        foreach (tbl[i]) run_txn(tbl[i]);

        // Result held in DONE while a later stage stalls.
        set_instr(ALUOP_LW, 32'h5000, 32'h0, 1'b1);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h0BADF00D;
        #1; chk1("hold_issue_stall", mem_stall_request_o, 1'b1);
        @(posedge clock_i); #1;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            stall_i = (i < 2);
            #1;
            chk1("hold_we", regfile_write_enable_o, 1'b1);
            chk("hold_rf", regfile_write_data_o, 32'h0BADF00D);
            chk1("hold_stall", mem_stall_request_o, 1'b0);
            chk1("hold_req", data_req_o, 1'b0);
            @(posedge clock_i); #1;
        end
        set_nop();

        // Flush while the request is still waiting for addr_ok.
        set_instr(ALUOP_LW, 32'h6000, 32'h0, 1'b1);
        #1; chk1("freq_req0", data_req_o, 1'b1);
        @(posedge clock_i); #1;
        flush_i = 1'b1;
        #1;
        chk1("freq_req1", data_req_o, 1'b1);
        chk1("freq_we", regfile_write_enable_o, 1'b0);
        @(posedge clock_i); #1;
        set_nop();
        #1;
        chk1("freq_after_req", data_req_o, 1'b0);
        chk1("freq_after_stall", mem_stall_request_o, 1'b0);
        @(posedge clock_i); #1;

        // Flush in WAIT; the response arrives two cycles later and is discarded.
        set_instr(ALUOP_LW, 32'h7000, 32'h0, 1'b1);
        data_addr_ok_i = 1'b1;
        #1; chk1("fwait_issue_req", data_req_o, 1'b1);
        @(posedge clock_i); #1;
        data_addr_ok_i = 1'b0;
        flush_i = 1'b1;
        #1;
        chk1("fwait_stall", mem_stall_request_o, 1'b1);
        chk1("fwait_req", data_req_o, 1'b0);
        chk1("fwait_we", regfile_write_enable_o, 1'b0);
        @(posedge clock_i); #1;
        set_nop();
        #1;
        chk1("drop_stall", mem_stall_request_o, 1'b1);
        chk1("drop_req", data_req_o, 1'b0);
        @(posedge clock_i); #1;
        data_data_ok_i = 1'b1; data_rdata_i = 32'h99999999;
        #1;
        chk1("drop_dataok_stall", mem_stall_request_o, 1'b1);
        chk1("drop_dataok_we", regfile_write_enable_o, 1'b0);
        @(posedge clock_i); #1;
        data_data_ok_i = 1'b0;
        #1;
        chk1("drop_done_stall", mem_stall_request_o, 1'b0);
        chk1("drop_done_we", regfile_write_enable_o, 1'b0);
        @(posedge clock_i); #1;
        run_txn(model_vec(ALUOP_LW, 32'h7004, 32'h0, 32'h13572468, 32'h0, 1'b1, 0, 1));

        // Reset asserted while waiting for data.
        set_instr(ALUOP_LW, 32'h8000, 32'h0, 1'b1);
        data_addr_ok_i = 1'b1;
        @(posedge clock_i); #1;
        data_addr_ok_i = 1'b0;
        reset_i = 1'b0;
        #1;
        check_all_zero("rst_wait");
        @(posedge clock_i); #1;
        set_nop();
        reset_i = 1'b1;
        #1;
        chk1("rst_wait_after_stall", mem_stall_request_o, 1'b0);
        @(posedge clock_i); #1;
        run_txn(model_vec(ALUOP_LW, 32'h8004, 32'h0, 32'hA5A55A5A, 32'h0, 1'b1, 1, 1));

        for (int i = 0; i < 40; i++) begin
            v = model_vec(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
                          ($urandom_range(0, 7) == 0) ? (32'd1 << $urandom_range(0, 25)) : 32'h0,
                          1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access pipeline stage directly downstream of the execute stage.
- Consumes execute outputs: ALU result/effective address, store data, regfile write info, exception vector.
- Drives a request/address-ok/data-ok data-bus handshake for loads and stores.
- Detects address-alignment exceptions and aligns/extends load data.
- Stalls the pipeline until the access completes; non-memory instructions pass through with zero added latency.

Parameters:
- ADDR_W, 32, data-bus address width.
- EXC_ADEL_BIT, 27, exception_type bit set on load/fetch address error.
- EXC_ADES_BIT, 26, exception_type bit set on store address error.

Ports:
- clock_i  in  1  sole clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- pc_i  in  32  PC of instruction in this stage.
- aluop_i  in  8  operation code; defines.vh ALUOP_* encodings.
- alu_data_i  in  32  ALU result; effective address for loads/stores.
- ram_write_data_i  in  32  store source (rt value).
- regfile_write_enable_i  in  1  instruction writes the regfile.
- regfile_write_addr_i  in  5  destination register.
- exception_type_i  in  32  exception vector from execute.
- stall_i  in  1  stall from a later stage or global control.
- flush_i  in  1  exception/flush; kill the instruction in this stage.
- data_req_o  out  1  bus request.
- data_wr_o  out  1  1 = store.
- data_size_o  out  2  0 = byte, 1 = half, 2 = word.
- data_addr_o  out  32  byte address.
- data_wdata_o  out  32  store data, lane-replicated.
- data_addr_ok_i  in  1  request accepted this cycle.
- data_data_ok_i  in  1  response valid this cycle.
- data_rdata_i  in  32  load data, valid with data_ok.
- pc_o  out  32  PC passthrough.
- regfile_write_enable_o  out  1  final regfile write enable.
- regfile_write_addr_o  out  5  destination passthrough.
- regfile_write_data_o  out  32  ALU result, or aligned/extended load data.
- exception_type_o  out  32  exception_type_i OR'd with address-error bits.
- bad_vaddr_o  out  32  faulting address; alu_data_i when an address error is raised, else 0.
- mem_stall_request_o  out  1  stage requests pipeline stall.

Behaviour:
- Memory op = ALUOP_LB/LBU/LH/LHU/LW/SB/SH/SW.
- Misaligned cases:
  - Half op with addr[0]=1 → misaligned.
  - Word op with addr[1:0]≠0 → misaligned.
  - Load misaligned sets EXC_ADEL_BIT; store misaligned sets EXC_ADES_BIT.
  - Misaligned op: no bus request, regfile_write_enable_o=0, mem_stall_request_o=0.
- "go" = memory op & aligned & exception_type_i==0 & !flush_i.
- FSM states IDLE, REQ, WAIT, DONE, DROP; async reset → IDLE, rdata_q=0.
- IDLE:
  - If go: data_req_o=1 combinationally.
  - addr_ok & data_ok → DONE; addr_ok only → WAIT; neither → REQ.
- REQ:
  - data_req_o held with stable addr/size/wr/wdata until addr_ok.
  - Same exits as IDLE.
  - flush_i before addr_ok → drop request, go to IDLE.
- WAIT:
  - data_req_o=0.
  - data_ok → DONE; capture data_rdata_i into rdata_q.
  - flush_i without data_ok → DROP.
  - flush_i with data_ok → IDLE.
- DONE:
  - Result valid, stall released.
  - !stall_i → IDLE next cycle; stall_i → hold DONE.
  - flush_i → IDLE.
- DROP: data_req_o=0, stall asserted, wait for data_ok, discard data, → IDLE.
- Data capture on the IDLE/REQ addr_ok & data_ok path is the same as WAIT.
- mem_stall_request_o = (IDLE & go) | REQ | WAIT | DROP.
  - Minimum memory latency: 1 stall cycle (addr_ok & data_ok in the issue cycle), result in DONE next cycle.
- Store data:
  - SB → {4{rt[7:0]}}.
  - SH → {2{rt[15:0]}}.
  - SW → rt.
- Load extraction from rdata_q:
  - LB/LBU: byte lane addr[1:0]; LB sign-extends, LBU zero-extends.
  - LH/LHU: half lane addr[1]; LH sign-extends, LHU zero-extends.
  - LW: full word.
- Stores: regfile_write_enable_o=0. Loads write in DONE only.
- Non-memory ops: regfile_write_data_o=alu_data_i; all other outputs pass through combinationally.
- flush_i forces regfile_write_enable_o=0 that cycle.
- Reset values: all outputs 0; data_req_o=0.
  - Reset mid-transaction abandons it; the bus side must tolerate this.

Optional Feature:
- Macro MEM_BYTE_STROBE_EN.
- Defined: adds port data_wstrb_o, out, 4, one-hot-per-byte write strobe.
  - SB → 4'b0001<<addr[1:0].
  - SH → 4'b0011<<{addr[1],1'b0}.
  - SW → 4'b1111.
  - 0 for loads and whenever data_req_o=0.
- Undefined: port absent; the bus derives lanes from data_size_o and data_addr_o.

Test Plan:
- LW addr 0x1000, addr_ok 2 cycles late, data_ok 1 later, rdata 0xDEADBEEF → req high 3 cycles, stall 4 cycles, DONE write data 0xDEADBEEF to rd.
- LB/LBU addr 0x1003, rdata 0x80FFFFFF → 0xFFFFFF80 / 0x00000080; LH addr 0x1002 rdata 0x8001xxxx → 0xFFFF8001.
- SH addr 0x2002, rt 0x1234ABCD → wdata 0xABCDABCD, size 1, wr 1, no regfile write (strobe 4'b1100 if MEM_BYTE_STROBE_EN).
- SW addr 0x1002 → no data_req_o, exception_type_o bit 26 set, bad_vaddr_o 0x1002, no stall.
- flush_i in WAIT, data_ok 2 cycles later → stall held until data_ok, state DROP→IDLE, no regfile write.
- reset_i low while in WAIT → immediate IDLE, all outputs 0, next LW completes normally.
